// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//   Multi-cycle radix-2 restoring divider with its sequencing FSM, serving the
//   EX stage's divide port. One quotient bit is produced per cycle on absolute
//   values. The sign fix-up is applied when the result is registered.
//
// Ports
//   clk       in   1        clock, all state on rising edge
//   rst       in   1        asynchronous, active-high reset
//   start     in   1        div_sel from EX (level, held until valid seen)
//   sign      in   1        1 = signed DIV, 0 = unsigned DIVU
//   flush     in   1        abort the current operation, return to IDLE
//   stall     in   1        hold DONE (valid and result) while high
//   dividend  in   WIDTH    operand rs
//   divisor   in   WIDTH    operand rt
//   result    out  2*WIDTH  {quotient, remainder}
//   valid     out  1        result valid, high in DONE only
//   busy      out  1        high in DIVZ and BUSY
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sign,
   input  logic                 flush,
   input  logic                 stall,
   input  logic [WIDTH-1:0]     dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic [2*WIDTH-1:0]   result,
   output logic                 valid,
   output logic                 busy
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIVZ = 2'd1,
      S_BUSY = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 qneg_q, qneg_d;     // quotient must be negated at the end
   logic                 rneg_q, rneg_d;     // remainder must be negated at the end
   logic [WIDTH-1:0]     dvsr_q, dvsr_d;     // |divisor|
   logic [WIDTH-1:0]     rem_q, rem_d;       // partial remainder
   logic [WIDTH-1:0]     quot_q, quot_d;     // |dividend| shifting out, quotient shifting in
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;

   logic [WIDTH:0]       rem_sh_s;
   logic [WIDTH:0]       trial_s;
   logic [WIDTH-1:0]     rem_n_s;
   logic [WIDTH-1:0]     quot_n_s;
   logic [WIDTH-1:0]     q_fix_s;
   logic [WIDTH-1:0]     r_fix_s;

   // Next-state, datapath iteration and registered-output computation.
   always_comb begin
      state_d  = state_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      dvsr_d   = dvsr_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      // One restoring step: shift {rem,quot} left, try subtracting the divisor.
      // With rem < divisor, a non-negative trial always fits in WIDTH bits, so
      // the top bit of the WIDTH+1 bit trial is exactly the "negative" flag.
      rem_sh_s = {rem_q, quot_q[WIDTH-1]};
      trial_s  = rem_sh_s - {1'b0, dvsr_q};
      rem_n_s  = trial_s[WIDTH] ? rem_sh_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
      quot_n_s = {quot_q[WIDTH-2:0], ~trial_s[WIDTH]};
      q_fix_s  = qneg_q ? -quot_n_s : quot_n_s;
      r_fix_s  = rneg_q ? -rem_n_s  : rem_n_s;

      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  qneg_d = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  rneg_d = sign & dividend[WIDTH-1];
                  quot_d = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
                  dvsr_d = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
                  rem_d  = '0;
                  cnt_d  = '0;
                  state_d = (divisor == '0) ? S_DIVZ : S_BUSY;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_DIVZ: begin
               state_d  = S_DONE;
               result_d = '0;
            end
            S_BUSY: begin
               rem_d  = rem_n_s;
               quot_d = quot_n_s;
               cnt_d  = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_d  = S_DONE;
                  result_d = {q_fix_s, r_fix_s};
               end else begin
                  state_d = S_BUSY;
               end
            end
            S_DONE: begin
               // start is deliberately ignored here so a held div_sel cannot
               // re-issue the instruction that just completed.
               state_d = stall ? S_DONE : S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      valid_d = (state_d == S_DONE);
      busy_d  = (state_d == S_DIVZ) || (state_d == S_BUSY);
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dvsr_q   <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         dvsr_q   <= dvsr_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign result = result_q;
   assign valid  = valid_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_seq_ctrl
//   Scoreboard bench for div_seq_ctrl. The driver pushes the expected result,
//   completion cycle and valid pulse width; an independent monitor pops an
//   entry on every rising edge of valid and compares.
// -----------------------------------------------------------------------------
module tb_div_seq_ctrl;

   localparam int W = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            sign = 1'b0;
   logic            flush = 1'b0;
   logic            stall = 1'b0;
   logic [W-1:0]    dividend = '0;
   logic [W-1:0]    divisor = '0;
   logic [2*W-1:0]  result;
   logic            valid;
   logic            busy;

   div_seq_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .sign(sign), .flush(flush),
      .stall(stall), .dividend(dividend), .divisor(divisor),
      .result(result), .valid(valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [2*W-1:0] res;
      int             cyc;
      int             w;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference: plain 64-bit arithmetic; C-style truncating division gives the
   // MIPS quotient/remainder signs, and 64 bits avoid the MIN/-1 overflow.
   function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      longint na, nb, q, r;
      logic [63:0] qv, rv;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         na = longint'($signed(a));
         nb = longint'($signed(b));
      end else begin
         na = longint'({32'd0, a});
         nb = longint'({32'd0, b});
      end
      q  = na / nb;
      r  = na % nb;
      qv = q;
      rv = r;
      return {qv[W-1:0], rv[W-1:0]};
   endfunction

   // Monitor: pops on valid rise, checks hold stability and pulse width.
   logic           v_prev = 1'b0;
   logic           cur_ok = 1'b0;
   exp_t           cur;
   int             vw = 0;
   logic [2*W-1:0] held;
   always @(negedge clk) begin
      if (rst) begin
         v_prev = 1'b0;
         cur_ok = 1'b0;
      end else begin
         if (valid && !v_prev) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: valid rose at cycle %0d with nothing expected", cyc);
               cur_ok = 1'b0;
            end else begin
               cur = sb_q.pop_front();
               cur_ok = 1'b1;
               if (result !== cur.res) begin
                  errors++;
                  $display("FAIL result: got %h expected %h", result, cur.res);
               end
               checks++;
               if (cyc != cur.cyc) begin
                  errors++;
                  $display("FAIL latency: valid at cycle %0d expected %0d", cyc, cur.cyc);
               end
            end
            vw = 1;
            held = result;
         end else if (valid && v_prev) begin
            vw++;
            checks++;
            if (result !== held) begin
               errors++;
               $display("FAIL hold: result %h changed from %h", result, held);
            end
         end else if (!valid && v_prev && cur_ok) begin
            checks++;
            if (vw != cur.w) begin
               errors++;
               $display("FAIL valid_width: got %0d expected %0d", vw, cur.w);
            end
            cur_ok = 1'b0;
         end
         v_prev = valid;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic wait_valid(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (valid) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: valid 0 expected 1 within 40 cycles", name);
      end
   endtask

   // One divide; optional DONE stall and operand scrambling while busy.
   task automatic do_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int nstall, input bit scramble);
      exp_t e;
      @(posedge clk); #1;
      start = 1'b1; sign = s; dividend = a; divisor = b;
      e.res = ref_div(s, a, b);
      e.cyc = cyc + ((b == 32'd0) ? 2 : 33);
      e.w   = nstall + 1;
      sb_q.push_back(e);
      @(negedge clk);
      @(negedge clk);
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      if (scramble) begin
         dividend = $urandom;
         divisor  = $urandom;
      end
      if (b != 32'd0) wait_valid("div");
      else begin
         @(negedge clk);
         chk("divz_valid", {63'd0, valid}, 64'd1);
      end
      chk("busy_in_done", {63'd0, busy}, 64'd0);
      stall = (nstall > 0);
      repeat (nstall) @(negedge clk);
      stall = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      logic [W-1:0] a, b;
      int mode;
      exp_t e;

      #2;
      chk("reset_result", result, 64'd0);
      chk("reset_valid", {63'd0, valid}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      do_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
      do_div(1'b1, -32'sd7, 32'd2, 0, 1'b1);
      do_div(1'b1, 32'd7, -32'sd2, 0, 1'b1);
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
      do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b1);
      do_div(1'b0, 32'd1234, 32'd0, 0, 1'b0);
      do_div(1'b1, -32'sd55, 32'd0, 1, 1'b0);
      do_div(1'b0, 32'd5, 32'd9, 5, 1'b1);

      // Flush in the middle of BUSY: no result, back to idle next edge.
      @(posedge clk); #1;
      start = 1'b1; sign = 1'b0; dividend = 32'd999; divisor = 32'd3;
      repeat (10) @(posedge clk);
      #1;
      chk("busy_before_flush", {63'd0, busy}, 64'd1);
      flush = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", {63'd0, busy}, 64'd0);
      chk("flush_valid", {63'd0, valid}, 64'd0);
      do_div(1'b0, 32'd1000, 32'd10, 0, 1'b0);

      // Back-to-back with start held: exactly two valid pulses.
      @(posedge clk); #1;
      start = 1'b1; sign = 1'b0; dividend = 32'd77; divisor = 32'd5;
      e.res = ref_div(1'b0, 32'd77, 32'd5); e.cyc = cyc + 33; e.w = 1;
      sb_q.push_back(e);
      e.res = ref_div(1'b0, 32'd4000, 32'd33); e.cyc = cyc + 67; e.w = 1;
      sb_q.push_back(e);
      wait_valid("b2b_first");
      dividend = 32'd4000; divisor = 32'd33;
      @(negedge clk);
      wait_valid("b2b_second");
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("b2b_no_third", {63'd0, busy}, 64'd0);

      // Asynchronous reset mid-BUSY clears outputs at once.
      @(posedge clk); #1;
      start = 1'b1; sign = 1'b1; dividend = 32'd50; divisor = 32'd6;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_result", result, 64'd0);
      chk("rst_mid_valid", {63'd0, valid}, 64'd0);
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 25; i++) begin
         a = $urandom;
         mode = $urandom_range(0, 3);
         case (mode)
            0: b = 32'($urandom_range(0, 15));
            1: b = $urandom;
            2: b = -32'($urandom_range(1, 15));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         do_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2), 1'b1);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
